// File: rtl/hpdmc_fmlarb_pkg.sv
// Shared constants and state encoding for the four-master FML arbiter.
package hpdmc_fmlarb_pkg;
  localparam int NMASTERS  = 4;
  localparam int BURST_LEN = 4;
  localparam int MIDX_W    = 2;

  localparam logic [MIDX_W-1:0] LAST_SERVED_RST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;
endpackage

// File: rtl/hpdmc_fmlarb_rr.sv
// Round-robin picker: first requesting index strictly after last_i, wrapping modulo NMASTERS.
module hpdmc_fmlarb_rr
  import hpdmc_fmlarb_pkg::*;
(
  input  logic [NMASTERS-1:0] req_i,
  input  logic [MIDX_W-1:0]   last_i,
  output logic [MIDX_W-1:0]   next_o,
  output logic                any_o
);

  logic [MIDX_W-1:0] idx;

  // Scan farthest-first so the nearest requester after last_i wins.
  always_comb begin
    next_o = last_i;
    any_o  = |req_i;
    idx    = '0;
    for (int k = NMASTERS; k >= 1; k--) begin
      idx = last_i + k[MIDX_W-1:0];
      if (req_i[idx]) next_o = idx;
    end
  end

endmodule

// File: rtl/hpdmc_fmlarb.sv
// Four-master FML arbiter: round-robin grant, one request phase, then a fixed 4-beat data phase.
module hpdmc_fmlarb
  import hpdmc_fmlarb_pkg::*;
#(
  parameter int sdram_depth = 26
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic [4*sdram_depth-1:0]        m_adr,
  input  logic [NMASTERS-1:0]             m_stb,
  input  logic [NMASTERS-1:0]             m_we,
  output logic [NMASTERS-1:0]             m_ack,
  input  logic [31:0]                     m_sel,
  input  logic [255:0]                    m_di,
  output logic [63:0]                     m_do,
  output logic [sdram_depth-1:0]          s_adr,
  output logic                            s_stb,
  output logic                            s_we,
  input  logic                            s_ack,
  output logic [7:0]                      s_sel,
  output logic [63:0]                     s_di,
  input  logic [63:0]                     s_do,
  output logic [MIDX_W-1:0]               grant,
  output logic                            busy
);

  state_t            state_q, state_d;
  logic [MIDX_W-1:0] grant_q, grant_d;
  logic [MIDX_W-1:0] last_q, last_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [MIDX_W-1:0] rr_next;
  logic              rr_any;
  logic              in_req;

  hpdmc_fmlarb_rr u_rr (
    .req_i  (m_stb),
    .last_i (last_q),
    .next_o (rr_next),
    .any_o  (rr_any)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_SERVED_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          grant_d = rr_next;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (s_ack) begin
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = ST_DATA;
        end else if (!m_stb[grant_q]) begin
          // Master withdrew before the controller took the request.
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(BURST_LEN - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_req = (state_q == ST_REQ);
  assign busy   = (state_q != ST_IDLE);
  assign grant  = grant_q;

  assign s_stb = in_req & m_stb[grant_q];
  assign s_we  = in_req & m_we[grant_q];
  assign s_adr = m_adr[grant_q*sdram_depth +: sdram_depth];
  assign s_sel = busy ? m_sel[grant_q*8 +: 8] : 8'd0;
  assign s_di  = busy ? m_di[grant_q*64 +: 64] : 64'd0;
  assign m_do  = s_do;

  always_comb begin
    m_ack          = '0;
    m_ack[grant_q] = in_req & s_ack;
  end

endmodule
